// File: rtl/bopit_pkg.sv
// Shared definitions for the Bopit game datapath: FSM encoding and display constants.
package bopit_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0]  ROUND_TICKS_DEFAULT = 8'd10;
    localparam int unsigned BCD_W               = 4;
    localparam int unsigned BCD_MAX             = 999;

endpackage

// File: rtl/bin2bcd.sv
// Combinational double-dabble: binary value to three BCD digits, saturating at 999.
module bin2bcd
    import bopit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] bin,
    output logic [BCD_W-1:0] hund_c,
    output logic [BCD_W-1:0] tens_c,
    output logic [BCD_W-1:0] ones_c
);

    localparam int unsigned ACC_W = 3 * BCD_W;

    logic             sat;
    logic [ACC_W-1:0] acc;

    // Only widths that can exceed 999 need a saturation compare.
    generate
        if (WIDTH >= 10) begin : g_sat
            assign sat = (bin > WIDTH'(BCD_MAX));
        end else begin : g_nosat
            assign sat = 1'b0;
        end
    endgenerate

    always_comb begin
        acc = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            for (int d = 0; d < 3; d++) begin
                if (acc[d*BCD_W +: BCD_W] >= BCD_W'(5))
                    acc[d*BCD_W +: BCD_W] = acc[d*BCD_W +: BCD_W] + BCD_W'(3);
            end
            acc = {acc[ACC_W-2:0], bin[i]};
        end
    end

    assign hund_c = sat ? BCD_W'(9) : acc[2*BCD_W +: BCD_W];
    assign tens_c = sat ? BCD_W'(9) : acc[1*BCD_W +: BCD_W];
    assign ones_c = sat ? BCD_W'(9) : acc[0*BCD_W +: BCD_W];

endmodule

// File: rtl/round_timer.sv
// Per-round response timer: counts down on synchronised tick edges, reports hit or timeout,
// and presents the remaining time in binary and registered BCD.
module round_timer
    import bopit_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             start,
    input  logic             hit,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] time_left,
    output logic             running,
    output logic             timeout,
    output logic             hit_ok,
    output logic [BCD_W-1:0] bcd_hund,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones
);

    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [SYNC_N-1:0] sync_q;
    logic              tick_prev;
    logic              tick_rise;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  time_left_d;
    logic              running_d;
    logic              timeout_d;
    logic              hit_ok_d;

    logic [BCD_W-1:0]  hund_c, tens_c, ones_c;

    // Edge register runs in every state so no stale edge survives into a new round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            tick_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_N-2:0], tick_in};
            tick_prev <= sync_q[SYNC_N-1];
        end
    end

    assign tick_rise = sync_q[SYNC_N-1] & ~tick_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            time_left <= '0;
            running   <= 1'b0;
            timeout   <= 1'b0;
            hit_ok    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_left <= time_left_d;
            running   <= running_d;
            timeout   <= timeout_d;
            hit_ok    <= hit_ok_d;
        end
    end

    // Round control: start beats hit, hit beats tick, a zero load expires without a tick.
    always_comb begin
        state_d     = state_q;
        time_left_d = time_left;
        running_d   = running;
        timeout_d   = 1'b0;
        hit_ok_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    time_left_d = load_val;
                    running_d   = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start) begin
                    time_left_d = load_val;
                end else if (hit) begin
                    hit_ok_d  = 1'b1;
                    running_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (time_left == '0) begin
                    timeout_d = 1'b1;
                    running_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (tick_rise) begin
                    if (time_left == WIDTH'(1)) begin
                        time_left_d = '0;
                        timeout_d   = 1'b1;
                        running_d   = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        time_left_d = time_left - WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                running_d = 1'b0;
            end
        endcase
    end

    bin2bcd #(
        .WIDTH (WIDTH)
    ) u_bin2bcd (
        .bin    (time_left),
        .hund_c (hund_c),
        .tens_c (tens_c),
        .ones_c (ones_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_hund <= '0;
            bcd_tens <= '0;
            bcd_ones <= '0;
        end else begin
            bcd_hund <= hund_c;
            bcd_tens <= tens_c;
            bcd_ones <= ones_c;
        end
    end

endmodule

// File: doc/round_timer.md
Name: round_timer

Overview:
Per-round response timer for the Bopit game; sits directly downstream of clock_divider and consumes its clk_out as a slow tick input.
- Samples the tick in the system clock domain and counts down one unit per rising tick edge.
- Reports whether the player hit in time or the round timed out.
- Exposes remaining time in binary and BCD for the display driver.

Parameters:
WIDTH, 8, width of the countdown value and load value
SYNC_STAGES, 2, flip-flop stages synchronising tick_in into clk (minimum 2)

Ports:
clk  input  1  system clock (100 MHz board clock)
reset  input  1  asynchronous, active-high reset
tick_in  input  1  divided clock from clock_divider clk_out; treated as asynchronous data
start  input  1  one-cycle pulse: load load_val and begin the round
hit  input  1  one-cycle pulse: player responded (already debounced upstream)
load_val  input  WIDTH  round length in ticks, sampled on start
time_left  output  WIDTH  remaining ticks
running  output  1  high while a round is active
timeout  output  1  one-cycle pulse when the count expires
hit_ok  output  1  one-cycle pulse when hit arrives while running
bcd_hund  output  4  BCD hundreds digit of time_left
bcd_tens  output  4  BCD tens digit of time_left
bcd_ones  output  4  BCD ones digit of time_left

Behaviour:
- One clock domain (clk). reset is asynchronous, active-high, and clears all registers:
  - state=IDLE, time_left=0, running=0, timeout=0, hit_ok=0, sync chain=0, edge register=0, BCD digits=0.
- Tick sync: tick_in passes through SYNC_STAGES flops. tick_rise = sync_out & ~prev.
  - Latency from a tick_in rising edge to the time_left decrement is SYNC_STAGES+1 clk cycles.
- FSM has two states: IDLE and RUN.
- IDLE:
  - start=1: time_left<=load_val, running<=1, go to RUN.
  - hit is ignored; hit_ok stays 0.
- RUN, priority highest first:
  1. start=1: reload time_left<=load_val, stay in RUN. Any hit or tick in the same cycle is ignored.
  2. hit=1: hit_ok pulses 1 cycle, running<=0, time_left frozen at its current value, go to IDLE. If a tick_rise coincides, hit wins: no decrement, no timeout.
  3. tick_rise=1:
     - time_left>1: decrement by 1.
     - time_left==1: time_left<=0, timeout pulses 1 cycle, running<=0, go to IDLE.
  4. time_left==0 in RUN (only when load_val==0 was loaded): timeout pulses on the next cycle without waiting for a tick; go to IDLE.
- timeout and hit_ok are registered, mutually exclusive, and each lasts exactly one clk cycle.
- No wrap-around: time_left never decrements below 0.
- tick_in levels or edges while in IDLE have no effect on the count. The edge register still tracks tick_in so a stale edge cannot fire on entry to RUN.
- BCD outputs:
  - Registered conversion of time_left, one cycle behind time_left.
  - WIDTH=8 gives a 0..255 range.
  - For WIDTH>8, values above 999 saturate the digits to 9,9,9.
- Reset asserted mid-round: outputs clear immediately (asynchronously), no timeout or hit_ok pulse. After deassertion the block waits in IDLE for start.

Decomposition:
- Shared package (bopit_pkg): state encoding constants ST_IDLE/ST_RUN, default round length constant ROUND_TICKS_DEFAULT=8'd10, BCD digit width constant.
- One sub-module: bin2bcd (combinational double-dabble, WIDTH in, three 4-bit digits out with saturation), instantiated once with its outputs registered in round_timer.

Test Plan:
- Reset then idle: assert reset for 100 ns with tick_in toggling every 50 ns -> all outputs 0; after release, time_left stays 0 and running stays 0.
- Normal timeout: load_val=3, pulse start, tick_in period 100 ns -> time_left goes 3,2,1,0, each step SYNC_STAGES+1 cycles after a tick rise; one timeout pulse; running falls with it; BCD reads 0,0,3 then 0,0,0 one cycle late.
- Hit in time: load_val=10, start, after 4 ticks pulse hit -> hit_ok single pulse, time_left frozen at 6, no timeout ever; further ticks leave 6.
- Simultaneous hit and final tick: time_left=1, hit asserted the same cycle tick_rise occurs -> hit_ok=1, timeout=0, time_left stays 1.
- Restart and zero load: in RUN at time_left=5, pulse start with load_val=200 -> time_left=200, BCD 2,0,0; then start with load_val=0 -> timeout pulse on the next cycle.
- Reset mid-round: time_left=7 in RUN, assert reset asynchronously between clk edges -> outputs clear before the next clk edge, no pulses; after release, ticks do not change time_left.
